weight_bram_writer: RTL and testbench

- Write side of the weight BRAM pair that the MAC array control reads through bram_control.
- Accepts weights from an AXI4-Stream slave, 4 weights per beat, and packs MAC_NUM 5-bit weights into one 5*MAC_NUM-bit row.
- Writes each row alternately to bank A (even rows) and bank B (odd rows).
- Pulses done after the last row is written; done is the load_weight_FSM_start source for the MAC array control.

---
 rtl/weight_bram_writer.sv | 188 ++++++++++++++++++
 tb/tb_weight_bram_writer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_writer.sv
// Packs AXI4-Stream weights (4 per beat, 5 bits each) into MAC_NUM-wide rows and
// writes them alternately to the two weight BRAM banks (even rows to A, odd rows to B).
module weight_bram_writer #(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic [BRAM_ADDRESS_WIDTH:0]     cfg_num_rows,
    input  logic [31:0]                     s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [5*MAC_NUM-1:0]            bram_wdata_A,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_waddr_A,
    output logic                            bram_we_A,
    output logic [5*MAC_NUM-1:0]            bram_wdata_B,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_waddr_B,
    output logic                            bram_we_B,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int AW    = BRAM_ADDRESS_WIDTH;
    localparam int ROW_W = 5 * MAC_NUM;
    localparam int BEATS = MAC_NUM / 4;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      numRows_q, numRows_d;
    logic [AW:0]      rowCnt_q, rowCnt_d;
    logic [BCW-1:0]   beatCnt_q, beatCnt_d;
    logic [ROW_W-1:0] rowBuf_q, rowBuf_d;
    logic             err_q, err_d;
    logic             endLoad_q, endLoad_d;
    logic             missLast_q, missLast_d;
    logic [ROW_W-1:0] wdataA_q, wdataA_d;
    logic [ROW_W-1:0] wdataB_q, wdataB_d;
    logic [AW-1:0]    waddrA_q, waddrA_d;
    logic [AW-1:0]    waddrB_q, waddrB_d;

    logic [19:0]      beatWeights;
    logic [ROW_W-1:0] rowWithBeat;
    logic             handshake;
    logic             lastBeat;
    logic             finalRow;

    // Only the low 5 bits of each byte carry a weight.
    assign beatWeights = {s_axis_tdata[28:24], s_axis_tdata[20:16],
                          s_axis_tdata[12:8],  s_axis_tdata[4:0]};

    assign handshake = (state_q == COLLECT) && s_axis_tvalid;
    assign lastBeat  = (beatCnt_q == LAST_BEAT);
    assign finalRow  = ((rowCnt_q + (AW+1)'(1)) == numRows_q);

    always_comb begin
        rowWithBeat = rowBuf_q;
        rowWithBeat[int'(beatCnt_q) * 20 +: 20] = beatWeights;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            numRows_q  <= '0;
            rowCnt_q   <= '0;
            beatCnt_q  <= '0;
            rowBuf_q   <= '0;
            err_q      <= 1'b0;
            endLoad_q  <= 1'b0;
            missLast_q <= 1'b0;
            wdataA_q   <= '0;
            wdataB_q   <= '0;
            waddrA_q   <= '0;
            waddrB_q   <= '0;
        end else begin
            state_q    <= state_d;
            numRows_q  <= numRows_d;
            rowCnt_q   <= rowCnt_d;
            beatCnt_q  <= beatCnt_d;
            rowBuf_q   <= rowBuf_d;
            err_q      <= err_d;
            endLoad_q  <= endLoad_d;
            missLast_q <= missLast_d;
            wdataA_q   <= wdataA_d;
            wdataB_q   <= wdataB_d;
            waddrA_q   <= waddrA_d;
            waddrB_q   <= waddrB_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        numRows_d  = numRows_q;
        rowCnt_d   = rowCnt_q;
        beatCnt_d  = beatCnt_q;
        rowBuf_d   = rowBuf_q;
        err_d      = err_q;
        endLoad_d  = endLoad_q;
        missLast_d = missLast_q;
        wdataA_d   = wdataA_q;
        wdataB_d   = wdataB_q;
        waddrA_d   = waddrA_q;
        waddrB_d   = waddrB_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    numRows_d  = cfg_num_rows;
                    rowCnt_d   = '0;
                    beatCnt_d  = '0;
                    err_d      = 1'b0;
                    endLoad_d  = 1'b0;
                    missLast_d = 1'b0;
                    state_d    = (cfg_num_rows == '0) ? DONE : COLLECT;
                end
            end

            COLLECT: begin
                if (handshake) begin
                    rowBuf_d = rowWithBeat;
                    if (lastBeat) begin
                        // Write data/address are staged here so they change together with we.
                        beatCnt_d = '0;
                        state_d   = WRITE;
                        if (!rowCnt_q[0]) begin
                            wdataA_d = rowWithBeat;
                            waddrA_d = rowCnt_q[AW:1];
                        end else begin
                            wdataB_d = rowWithBeat;
                            waddrB_d = rowCnt_q[AW:1];
                        end
                        endLoad_d  = finalRow || s_axis_tlast;
                        missLast_d = finalRow && !s_axis_tlast;
                        if (!finalRow && s_axis_tlast) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        beatCnt_d = beatCnt_q + BCW'(1);
                        if (s_axis_tlast) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end

            WRITE: begin
                rowCnt_d = rowCnt_q + (AW+1)'(1);
                if (endLoad_q) begin
                    err_d   = err_q | missLast_q;
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_axis_tready = (state_q == COLLECT);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign bram_we_A     = (state_q == WRITE) && !rowCnt_q[0];
    assign bram_we_B     = (state_q == WRITE) &&  rowCnt_q[0];
    assign bram_wdata_A  = wdataA_q;
    assign bram_wdata_B  = wdataB_q;
    assign bram_waddr_A  = waddrA_q;
    assign bram_waddr_B  = waddrB_q;

endmodule

// File: tb/tb_weight_bram_writer.sv
// Directed self-checking bench for weight_bram_writer with MAC_NUM=8 (2 beats per row)
// and a 4-bit bank address; a negedge monitor mirrors both banks as simple memories.
module tb_weight_bram_writer;

    localparam int MAC_NUM = 8;
    localparam int AW      = 4;
    localparam int ROW_W   = 5 * MAC_NUM;

    localparam logic [ROW_W-1:0] ROW0 = {5'd8,  5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1};
    localparam logic [ROW_W-1:0] ROW1 = {5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9};
    localparam logic [ROW_W-1:0] ROW2 = {5'd24, 5'd23, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd17};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start;
    logic [AW:0]       cfg_num_rows;
    logic [31:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [ROW_W-1:0]  bram_wdata_A;
    logic [AW-1:0]     bram_waddr_A;
    logic              bram_we_A;
    logic [ROW_W-1:0]  bram_wdata_B;
    logic [AW-1:0]     bram_waddr_B;
    logic              bram_we_B;
    logic              busy;
    logic              done;
    logic              err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0]      beatMem [8];
    logic [ROW_W-1:0] memA [16];
    logic [ROW_W-1:0] memB [16];
    int               weACnt;
    int               weBCnt;
    int               bothCnt;
    int               doneCnt;

    weight_bram_writer #(
        .MAC_NUM(MAC_NUM),
        .BRAM_ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_start(cfg_start),
        .cfg_num_rows(cfg_num_rows),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .bram_wdata_A(bram_wdata_A),
        .bram_waddr_A(bram_waddr_A),
        .bram_we_A(bram_we_A),
        .bram_wdata_B(bram_wdata_B),
        .bram_waddr_B(bram_waddr_B),
        .bram_we_B(bram_we_B),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Behaves as the two BRAM banks, plus event counters for write enables and done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_we_A) begin
                memA[bram_waddr_A] = bram_wdata_A;
                weACnt = weACnt + 1;
            end
            if (bram_we_B) begin
                memB[bram_waddr_B] = bram_wdata_B;
                weBCnt = weBCnt + 1;
            end
            if (bram_we_A && bram_we_B) bothCnt = bothCnt + 1;
            if (done) doneCnt = doneCnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last);
        s_axis_tvalid = valid;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
    endtask

    task automatic clearCounters();
        weACnt  = 0;
        weBCnt  = 0;
        bothCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 16; i++) begin
            memA[i] = '0;
            memB[i] = '0;
        end
    endtask

    task automatic startLoad(input logic [AW:0] rows);
        cfg_num_rows = rows;
        cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
    endtask

    // Presents beatMem[0..n-1]; tlast accompanies beat lastIdx (-1 for none).
    task automatic sendBeats(input int n, input int lastIdx, input bit gaps, input bit pokeStart);
        int sent = 0;
        int cyc  = 0;
        logic hs;
        while (sent < n && cyc < 300) begin
            applyStimulus(gaps ? 1'($urandom_range(0, 1)) : 1'b1, beatMem[sent], sent == lastIdx);
            if (pokeStart && cyc == 3) begin
                cfg_num_rows = 5'd1;
                cfg_start    = 1'b1;
            end
            hs = s_axis_tvalid && s_axis_tready;
            tick();
            cfg_start = 1'b0;
            cyc++;
            if (hs) sent++;
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("beatsAccepted", 64'(sent), 64'(n));
    endtask

    task automatic waitDone(output logic errAtDone);
        int cyc = 0;
        errAtDone = 1'bx;
        while (done !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput("doneReached", 64'(done), 64'd1);
        errAtDone = err;
        tick();
    endtask

    initial begin
        logic errSeen;
        int   bi;
        logic hs;

        rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_num_rows = '0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        clearCounters();
        beatMem[0] = 32'h04030201; beatMem[1] = 32'h08070605;
        beatMem[2] = 32'h0C0B0A09; beatMem[3] = 32'h100F0E0D;
        beatMem[4] = 32'h14131211; beatMem[5] = 32'h18171615;
        beatMem[6] = 32'h0;        beatMem[7] = 32'h0;
        repeat (3) tick();

        checkOutput("rstBusy",   64'(busy), 64'd0);
        checkOutput("rstDone",   64'(done), 64'd0);
        checkOutput("rstTready", 64'(s_axis_tready), 64'd0);
        checkOutput("rstWeA",    64'(bram_we_A), 64'd0);
        checkOutput("rstWeB",    64'(bram_we_B), 64'd0);
        checkOutput("rstWdataA", 64'(bram_wdata_A), 64'd0);
        checkOutput("rstWdataB", 64'(bram_wdata_B), 64'd0);
        checkOutput("rstWaddrA", 64'(bram_waddr_A), 64'd0);
        checkOutput("rstWaddrB", 64'(bram_waddr_B), 64'd0);
        checkOutput("rstErr",    64'(err), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] three-row load with tvalid held high");
        startLoad(5'd3);
        checkOutput("t1Busy",   64'(busy), 64'd1);
        checkOutput("t1Tready", 64'(s_axis_tready), 64'd1);
        bi = 0;
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(bi < 6, beatMem[bi < 6 ? bi : 5], bi == 5);
            hs = s_axis_tvalid && s_axis_tready;
            tick();
            if (hs) bi++;
            checkOutput($sformatf("t1WeA@%0d", e), 64'(bram_we_A), 64'(e == 2 || e == 8));
            checkOutput($sformatf("t1WeB@%0d", e), 64'(bram_we_B), 64'(e == 5));
            checkOutput($sformatf("t1Done@%0d", e), 64'(done), 64'(e == 9));
            if (e == 9) checkOutput("t1Err", 64'(err), 64'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t1BusyEnd", 64'(busy), 64'd0);
        checkOutput("t1MemA0", 64'(memA[0]), 64'(ROW0));
        checkOutput("t1MemB0", 64'(memB[0]), 64'(ROW1));
        checkOutput("t1MemA1", 64'(memA[1]), 64'(ROW2));
        checkOutput("t1Both",  64'(bothCnt), 64'd0);

        $display("[TB] packing with upper byte bits set");
        clearCounters();
        beatMem[0] = 32'hE4E3E2E1; beatMem[1] = 32'hE8E7E6E5;
        startLoad(5'd1);
        sendBeats(2, 1, 1'b0, 1'b0);
        waitDone(errSeen);
        checkOutput("pkWdataA", 64'(bram_wdata_A), 64'(ROW0));
        checkOutput("pkMemA0",  64'(memA[0]), 64'(ROW0));
        checkOutput("pkErr",    64'(errSeen), 64'd0);

        $display("[TB] early tlast on the last beat of the first of two rows");
        clearCounters();
        beatMem[0] = 32'h0C0B0A09; beatMem[1] = 32'h100F0E0D;
        startLoad(5'd2);
        sendBeats(2, 1, 1'b0, 1'b0);
        waitDone(errSeen);
        checkOutput("etErr",   64'(errSeen), 64'd1);
        checkOutput("etMemA0", 64'(memA[0]), 64'(ROW1));
        checkOutput("etWeA",   64'(weACnt), 64'd1);
        checkOutput("etWeB",   64'(weBCnt), 64'd0);
        checkOutput("etDones", 64'(doneCnt), 64'd1);
        checkOutput("etErrHeld", 64'(err), 64'd1);

        $display("[TB] single row without tlast; start clears err");
        clearCounters();
        beatMem[0] = 32'h14131211; beatMem[1] = 32'h18171615;
        startLoad(5'd1);
        checkOutput("mlErrCleared", 64'(err), 64'd0);
        sendBeats(2, -1, 1'b0, 1'b0);
        waitDone(errSeen);
        checkOutput("mlErr",   64'(errSeen), 64'd1);
        checkOutput("mlMemA0", 64'(memA[0]), 64'(ROW2));
        checkOutput("mlDones", 64'(doneCnt), 64'd1);

        $display("[TB] zero-row load");
        clearCounters();
        applyStimulus(1'b1, 32'h01010101, 1'b1);
        startLoad(5'd0);
        checkOutput("zrDone",   64'(done), 64'd1);
        checkOutput("zrTready", 64'(s_axis_tready), 64'd0);
        checkOutput("zrErr",    64'(err), 64'd0);
        tick();
        checkOutput("zrDoneLow", 64'(done), 64'd0);
        checkOutput("zrBusyLow", 64'(busy), 64'd0);
        checkOutput("zrTready2", 64'(s_axis_tready), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("zrWrites", 64'(weACnt + weBCnt), 64'd0);

        $display("[TB] three rows with random tvalid gaps and a stray cfg_start");
        clearCounters();
        beatMem[0] = 32'h04030201; beatMem[1] = 32'h08070605;
        beatMem[2] = 32'h0C0B0A09; beatMem[3] = 32'h100F0E0D;
        beatMem[4] = 32'h14131211; beatMem[5] = 32'h18171615;
        startLoad(5'd3);
        sendBeats(6, 5, 1'b1, 1'b1);
        waitDone(errSeen);
        checkOutput("gpErr",   64'(errSeen), 64'd0);
        checkOutput("gpMemA0", 64'(memA[0]), 64'(ROW0));
        checkOutput("gpMemB0", 64'(memB[0]), 64'(ROW1));
        checkOutput("gpMemA1", 64'(memA[1]), 64'(ROW2));
        checkOutput("gpWrites", 64'(weACnt + weBCnt), 64'd3);
        checkOutput("gpDones", 64'(doneCnt), 64'd1);
        checkOutput("gpBoth",  64'(bothCnt), 64'd0);

        $display("[TB] reset in the middle of a row, then a clean load");
        clearCounters();
        startLoad(5'd2);
        sendBeats(1, -1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrBusy",   64'(busy), 64'd0);
        checkOutput("mrDone",   64'(done), 64'd0);
        checkOutput("mrTready", 64'(s_axis_tready), 64'd0);
        checkOutput("mrWeA",    64'(bram_we_A), 64'd0);
        checkOutput("mrWdataA", 64'(bram_wdata_A), 64'd0);
        checkOutput("mrWaddrA", 64'(bram_waddr_A), 64'd0);
        checkOutput("mrWdataB", 64'(bram_wdata_B), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("mrNoDone", 64'(doneCnt), 64'd0);
        startLoad(5'd2);
        sendBeats(4, 3, 1'b0, 1'b0);
        waitDone(errSeen);
        checkOutput("mrErr",   64'(errSeen), 64'd0);
        checkOutput("mrMemA0", 64'(memA[0]), 64'(ROW0));
        checkOutput("mrMemB0", 64'(memB[0]), 64'(ROW1));
        checkOutput("mrDones", 64'(doneCnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
